// File: rtl/segment_transition_ctl_pkg.sv
// Shared types and constants for the segment transition controller.
// Transition mode codes, the controller state encoding, the repeat-count
// sentinel and a helper that recognises legal mode codes.
package segment_transition_ctl_pkg;

  localparam int NumSegment = 2;
  localparam int RepWidth = 16;
  localparam logic [RepWidth-1:0] RepInfinite = 16'hFFFF;

  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    STOPPED = 2'd2
  } segment_state_t;

  // True for the mode codes this controller knows how to act on.
  function automatic logic mode_known(input logic [7:0] mode);
    logic known;
    known = 1'b0;
    case (mode)
      MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/segment_transition_ctl_trigger.sv
// Swap-trigger evaluation for the segment transition controller.
// Holds the registered GPIO history used for rising-edge detection and
// selects the trigger condition for the latched transition mode.
module segment_transition_trigger
  import segment_transition_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mode,
  input  logic [63:0] value,
  input  logic        idx_wrap,
  input  logic [63:0] sys_time,
  input  logic [3:0]  gpio_in,
  input  logic        was_stopped,
  output logic        trigger
);

  logic [3:0] gpio_prev;

  // One-cycle history of the GPIO inputs for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_prev <= '0;
    end else begin
      gpio_prev <= gpio_in;
    end
  end

  // Trigger condition for the latched mode; unknown codes never fire.
  always_comb begin
    trigger = 1'b0;
    case (mode)
      MODE_SYNC_IDX, MODE_EXT: trigger = idx_wrap | was_stopped;
      MODE_SYS_TIME:           trigger = (sys_time >= value);
      MODE_GPIO:               trigger = gpio_in[value[1:0]] & ~gpio_prev[value[1:0]];
      default:                 trigger = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_transition_ctl.sv
// Read-segment sequencer for one double-buffered memory (MOD or STM).
// Latches a host request on UPDATE_SETTINGS, swaps the active segment when
// the selected trigger fires, and counts passes to raise STOP when a finite
// repeat count runs out. EXT mode keeps toggling segments on every wrap.
// Optional build macro SEGMENT_TRANSITION_MISS_DETECT_EN adds a sticky MISSED
// flag for SYS_TIME targets that were already in the past when requested.
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                UPDATE_SETTINGS,
  input  logic                REQ_RD_SEGMENT,
  input  logic [RepWidth-1:0] REP,
  input  logic [7:0]          TRANSITION_MODE,
  input  logic [63:0]         TRANSITION_VALUE,
  input  logic                IDX_WRAP,
  input  logic [63:0]         SYS_TIME,
  input  logic [3:0]          GPIO_IN,
  output logic                SEGMENT,
  output logic                IDX_RST,
  output logic                STOP,
  output logic                WAITING
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
  ,
  output logic                MISSED
`endif
);

  localparam int SegW = $clog2(NumSegment);

  segment_state_t      state;
  logic [SegW-1:0]     req_l;
  logic [RepWidth-1:0] rep_l;
  logic [RepWidth-1:0] loop_cnt;
  logic [7:0]          mode_l;
  logic [63:0]         value_l;
  logic                was_stopped;
  logic                trigger;
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
  logic                first_wait;
`endif

  segment_transition_trigger u_trigger (
    .clk         (CLK),
    .rst         (RST),
    .mode        (mode_l),
    .value       (value_l),
    .idx_wrap    (IDX_WRAP),
    .sys_time    (SYS_TIME),
    .gpio_in     (GPIO_IN),
    .was_stopped (was_stopped),
    .trigger     (trigger)
  );

  // Controller FSM: config latch, swap on trigger, pass counting and EXT toggling.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= RUN;
      SEGMENT     <= 1'b0;
      IDX_RST     <= 1'b0;
      STOP        <= 1'b0;
      WAITING     <= 1'b0;
      req_l       <= '0;
      rep_l       <= RepInfinite;
      loop_cnt    <= '0;
      mode_l      <= MODE_SYNC_IDX;
      value_l     <= '0;
      was_stopped <= 1'b0;
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
      first_wait  <= 1'b0;
      MISSED      <= 1'b0;
`endif
    end else begin
      IDX_RST     <= 1'b0;
      // Lets SYNC_IDX/EXT swap immediately when leaving STOPPED: no wrap will come.
      was_stopped <= (state == STOPPED);
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
      first_wait  <= 1'b0;
`endif
      if (UPDATE_SETTINGS) begin
        // A new request always wins over a trigger firing in the same cycle.
        if (mode_known(TRANSITION_MODE)) begin
          req_l   <= REQ_RD_SEGMENT;
          rep_l   <= REP;
          mode_l  <= TRANSITION_MODE;
          value_l <= TRANSITION_VALUE;
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
          MISSED  <= 1'b0;
`endif
          if (REQ_RD_SEGMENT == SEGMENT) begin
            loop_cnt <= '0;
            STOP     <= 1'b0;
            WAITING  <= 1'b0;
            state    <= RUN;
          end else begin
            WAITING  <= 1'b1;
            state    <= WAIT;
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
            first_wait <= 1'b1;
`endif
          end
        end
      end else begin
        case (state)
          RUN: begin
            if (IDX_WRAP) begin
              if (mode_l == MODE_EXT) begin
                SEGMENT <= ~SEGMENT;
                IDX_RST <= 1'b1;
              end else if (rep_l != RepInfinite) begin
                if (loop_cnt == rep_l) begin
                  STOP  <= 1'b1;
                  state <= STOPPED;
                end else begin
                  loop_cnt <= loop_cnt + 1'b1;
                end
              end
            end
          end
          WAIT: begin
            if (trigger) begin
              SEGMENT  <= req_l;
              IDX_RST  <= 1'b1;
              loop_cnt <= '0;
              STOP     <= 1'b0;
              WAITING  <= 1'b0;
              state    <= RUN;
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
              if (first_wait && (mode_l == MODE_SYS_TIME)) begin
                MISSED <= 1'b1;
              end
`endif
            end
          end
          STOPPED: begin
            state <= STOPPED;
          end
          default: begin
            state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl: a per-cycle vector table for the
// single-cycle behaviour plus hand-written SYS_TIME, GPIO and reset sequences.
// Build with SEGMENT_TRANSITION_MISS_DETECT_EN defined to cover MISSED.
module tb_segment_transition_ctl;
  import segment_transition_ctl_pkg::*;

  logic        clk;
  logic        rst;
  logic        update_settings;
  logic        req_rd_segment;
  logic [15:0] rep;
  logic [7:0]  transition_mode;
  logic [63:0] transition_value;
  logic        idx_wrap;
  logic [63:0] sys_time;
  logic [3:0]  gpio_in;
  logic        segment;
  logic        idx_rst;
  logic        stop;
  logic        waiting;
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
  logic        missed;
`endif

  int n_checks = 0;
  int n_fail = 0;

  segment_transition_ctl dut (
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
    .MISSED           (missed),
`endif
    .CLK              (clk),
    .RST              (rst),
    .UPDATE_SETTINGS  (update_settings),
    .REQ_RD_SEGMENT   (req_rd_segment),
    .REP              (rep),
    .TRANSITION_MODE  (transition_mode),
    .TRANSITION_VALUE (transition_value),
    .IDX_WRAP         (idx_wrap),
    .SYS_TIME         (sys_time),
    .GPIO_IN          (gpio_in),
    .SEGMENT          (segment),
    .IDX_RST          (idx_rst),
    .STOP             (stop),
    .WAITING          (waiting)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One record per clock: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic        upd;
    logic        req;
    logic [15:0] rep;
    logic [7:0]  mode;
    logic        wrap;
    logic        e_seg;
    logic        e_rst;
    logic        e_stop;
    logic        e_wait;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic upd, input logic req, input logic [15:0] r,
                     input logic [7:0] mode, input logic wrap, input logic e_seg,
                     input logic e_rst, input logic e_stop, input logic e_wait);
    vec_t v;
    v.upd = upd; v.req = req; v.rep = r; v.mode = mode; v.wrap = wrap;
    v.e_seg = e_seg; v.e_rst = e_rst; v.e_stop = e_stop; v.e_wait = e_wait;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic e_seg, input logic e_rst,
                           input logic e_stop, input logic e_wait);
    check({tag, "_segment"}, 64'(segment), 64'(e_seg));
    check({tag, "_idx_rst"}, 64'(idx_rst), 64'(e_rst));
    check({tag, "_stop"},    64'(stop),    64'(e_stop));
    check({tag, "_waiting"}, 64'(waiting), 64'(e_wait));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    update_settings = 1'b0;
    idx_wrap = 1'b0;
  endtask

  task automatic request(input logic req, input logic [15:0] r, input logic [7:0] mode,
                         input logic [63:0] value);
    update_settings  = 1'b1;
    req_rd_segment   = req;
    rep              = r;
    transition_mode  = mode;
    transition_value = value;
  endtask

  localparam logic [15:0] INF = 16'hFFFF;
  localparam logic [7:0] SI = MODE_SYNC_IDX;
  localparam logic [7:0] EX = MODE_EXT;
  localparam logic [7:0] BAD = 8'h7F;

  initial begin
    rst = 1'b1;
    update_settings = 1'b0; req_rd_segment = 1'b0; rep = 16'h0;
    transition_mode = 8'h0; transition_value = 64'h0; idx_wrap = 1'b0;
    sys_time = 64'h0; gpio_in = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
    check("reset_missed", 64'(missed), 64'h0);
`endif

    // Reset repeat count is infinite: wraps never stop.
    add(0,0,INF,SI,1, 0,0,0,0);
    add(0,0,INF,SI,1, 0,0,0,0);
    // REP=2 on the active segment: STOP after the 3rd wrap, later wraps ignored.
    add(1,0,16'd2,SI,0, 0,0,0,0);
    add(0,0,INF,SI,1, 0,0,0,0);
    add(0,0,INF,SI,0, 0,0,0,0);
    add(0,0,INF,SI,1, 0,0,0,0);
    add(0,0,INF,SI,1, 0,0,1,0);
    add(0,0,INF,SI,1, 0,0,1,0);
    add(0,0,INF,SI,1, 0,0,1,0);
    // Same-segment refresh clears STOP; then request seg 1 on SYNC_IDX.
    add(1,0,INF,SI,0, 0,0,0,0);
    add(1,1,INF,SI,0, 0,0,0,1);
    for (int i = 0; i < 9; i++) add(0,0,INF,SI,0, 0,0,0,1);
    add(0,0,INF,SI,1, 1,1,0,0);
    add(0,0,INF,SI,0, 1,0,0,0);
    // REP=0 stops on first wrap; leaving STOPPED on SYNC_IDX swaps on first WAIT cycle.
    add(1,1,16'd0,SI,0, 1,0,0,0);
    add(0,0,INF,SI,1, 1,0,1,0);
    add(1,0,INF,SI,0, 1,0,1,1);
    add(0,0,INF,SI,0, 0,1,0,0);
    // EXT: wrap swaps 0->1, then every wrap toggles with one IDX_RST.
    add(1,1,INF,EX,0, 0,0,0,1);
    add(0,0,INF,SI,1, 1,1,0,0);
    add(0,0,INF,SI,0, 1,0,0,0);
    add(0,0,INF,SI,1, 0,1,0,0);
    add(0,0,INF,SI,0, 0,0,0,0);
    add(0,0,INF,SI,1, 1,1,0,0);
    // Unknown mode in WAIT is dropped; pending request to seg 0 survives.
    add(1,0,INF,SI,0, 1,0,0,1);
    add(1,1,INF,BAD,0, 1,0,0,1);
    add(0,0,INF,SI,0, 1,0,0,1);
    add(0,0,INF,SI,1, 0,1,0,0);
    // Update coinciding with a trigger wins; new same-segment request cancels WAIT.
    add(1,1,INF,SI,0, 0,0,0,1);
    add(1,0,INF,SI,1, 0,0,0,0);
    add(0,0,INF,SI,0, 0,0,0,0);

    foreach (vecs[i]) begin
      update_settings  = vecs[i].upd;
      req_rd_segment   = vecs[i].req;
      rep              = vecs[i].rep;
      transition_mode  = vecs[i].mode;
      transition_value = 64'h0;
      idx_wrap         = vecs[i].wrap;
      tick();
      check_out($sformatf("row%0d", i), vecs[i].e_seg, vecs[i].e_rst,
                vecs[i].e_stop, vecs[i].e_wait);
    end
    idle_inputs();

    // SYS_TIME ramp: swap registered on the edge after SYS_TIME reaches 1000.
    sys_time = 64'd990;
    request(1'b1, INF, MODE_SYS_TIME, 64'd1000);
    tick();
    idle_inputs();
    check_out("st_latch", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int t = 991; t <= 1003; t++) begin
      sys_time = 64'(t);
      tick();
      check_out($sformatf("st_t%0d", t), (t >= 1000), (t == 1000), 1'b0, (t < 1000));
    end

    // Target already in the past: swap still happens on the first WAIT cycle.
    request(1'b0, INF, MODE_SYS_TIME, 64'd500);
    tick();
    idle_inputs();
    check_out("past_latch", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    check_out("past_swap", 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
    check("past_missed", 64'(missed), 64'h1);
    tick();
    check("past_missed_sticky", 64'(missed), 64'h1);
`endif

    // GPIO select 2: activity on bit 0 ignored, rising edge on bit 2 swaps.
    request(1'b1, INF, MODE_GPIO, 64'd2);
    tick();
    idle_inputs();
    check_out("gp_latch", 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
    check("gp_missed_cleared", 64'(missed), 64'h0);
`endif
    for (int i = 0; i < 4; i++) begin
      gpio_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      check_out($sformatf("gp_bit0_%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    gpio_in = 4'b0100;
    tick();
    check_out("gp_rise", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("gp_hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    // Held-high level does not count as an edge for a new request.
    request(1'b0, INF, MODE_GPIO, 64'd2);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("gp_level%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    gpio_in = 4'b0000;
    tick();
    check_out("gp_fall", 1'b1, 1'b0, 1'b0, 1'b1);
    gpio_in = 4'b0100;
    tick();
    check_out("gp_rise2", 1'b0, 1'b1, 1'b0, 1'b0);
    gpio_in = 4'b0000;

    // Asynchronous reset in the middle of WAIT on segment 1.
    request(1'b1, INF, MODE_SYS_TIME, 64'd0);
    tick();
    idle_inputs();
    tick();
    check_out("rw_swap", 1'b1, 1'b1, 1'b0, 1'b0);
    request(1'b0, INF, MODE_SYS_TIME, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    idle_inputs();
    tick();
    check_out("rw_pending", 1'b1, 1'b0, 1'b0, 1'b1);
    #1 rst = 1'b1;
    #1 check_out("rw_async", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEGMENT_TRANSITION_MISS_DETECT_EN
    check("rw_missed", 64'(missed), 64'h0);
`endif
    #1 rst = 1'b0;
    tick();
    check_out("rw_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while STOPPED restores the infinite repeat count.
    request(1'b0, 16'd0, MODE_SYNC_IDX, 64'd0);
    tick();
    idle_inputs();
    idx_wrap = 1'b1;
    tick();
    idx_wrap = 1'b0;
    check_out("rs_stopped", 1'b0, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 check_out("rs_async", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    idx_wrap = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("rs_wrap%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idx_wrap = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
